decoder_onehot_seq: RTL
=======================

// Module: decoder_onehot_seq
// PURPOSE
//   Parametrised registered binary-to-one-hot decoder: SEL_W-bit select to NUM_OUT strobes.
//   Adds a valid/ready input handshake, level (hold) or timed-pulse output mode, and live enable.
//   Drives chip-select, write-strobe and interrupt-steering lines where a glitch-free registered
//   one-hot output is required.
// PARAMETERS
//   SEL_W      2   select width, >=1
//   NUM_OUT    4   outputs, 2 <= NUM_OUT <= 2**SEL_W
//   PULSE_LEN  4   pulse-mode strobe length in cycles, >=1
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   en_i        in   1        enable; low clears the output, as the 2:4 decoder En does
//   mode_i      in   1        0 = HOLD (level), 1 = PULSE; sampled only on accept
//   in_valid_i  in   1        sel_i/mode_i valid
//   in_ready_o  out  1        block can accept
//   sel_i       in   SEL_W    binary select
//   y_o         out  NUM_OUT  registered one-hot output
//   busy_o      out  1        pulse in progress (state PULSE)
//   err_o       out  1        out-of-range select flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; cnt=0; y_o=0; busy_o=0; err_o=0; in_ready_o=1.
//   accept = in_valid_i & in_ready_o; in_ready_o = (state!=PULSE) | (cnt==0).
//   States: IDLE (y_o=0), HOLD (y_o held), PULSE (y_o held, cnt counting down).
//   Accept with en_i=1 and sel_i<NUM_OUT: next edge y_o = 1<<sel_i (latency 1).
//     mode_i=0 -> HOLD. mode_i=1 -> PULSE with cnt=PULSE_LEN-1.
//   Accept with en_i=0: the transaction is consumed; y_o=0; state IDLE.
//   Accept with sel_i>=NUM_OUT: y_o=0; state IDLE; err_o per CONFIGURATION.
//   HOLD: y_o is stable until the next accept, which replaces it with no zero gap.
//   PULSE: cnt decrements each cycle; y_o is high for exactly PULSE_LEN cycles.
//     When cnt==0 with no accept: next edge y_o=0, state IDLE.
//     Accept during the cnt==0 cycle: back-to-back, the new code appears next edge with no gap.
//     PULSE_LEN=1: single-cycle strobe; in_ready_o stays high.
//   en_i low in any state, no accept: next edge y_o=0, cnt=0, state IDLE.
//     en_i low takes priority over pulse completion.
//   y_o is always one-hot or zero, never multi-hot. Transitions change all bits on one clock edge.
//   Reset asserted mid-pulse: immediate clear to reset values; no completion.
// CONFIGURATION
//   DECODER_OOR_CHECK_EN defined:
//     err_o pulses high for 1 cycle, on the edge after an accept with sel_i>=NUM_OUT (en_i=1).
//   DECODER_OOR_CHECK_EN undefined:
//     err_o tied 0; out-of-range sel_i still gives y_o=0 and state IDLE.
//   With NUM_OUT==2**SEL_W, out-of-range cannot occur and err_o stays 0.
// STRUCTURE
//   Package decoder_pkg:
//     state encoding localparams IDLE/HOLD/PULSE.
//     function onehot(sel, NUM_OUT) returning a zero vector when out of range.
//     clog2-based counter width helper.
//   Sub-module decoder_pulse_timer: cnt load/decrement/clear, with outputs done (cnt==0) and active.
//   The top level holds the FSM, output register and handshake.
// TESTING
//   1. Reset with en_i=1, in_valid_i=1 -> y_o=0, in_ready_o=1, err_o=0 while rst_n=0.
//   2. HOLD sweep, sel 0..3 back-to-back, mode 0 -> y_o=0001,0010,0100,1000, each 1 cycle after accept.
//   3. PULSE, sel=2, PULSE_LEN=4 -> y_o=0100 for 4 cycles, then 0.
//      in_ready_o low for 3 cycles; accept on the 4th gives a gapless next code.
//   4. en_i low for 1 cycle mid-HOLD and mid-PULSE -> y_o=0 next edge, state IDLE, busy_o=0.
//   5. NUM_OUT=3, sel=3 -> y_o=0; err_o=1 for 1 cycle with the macro, 0 without.
//   6. rst_n asserted on pulse cycle 2 -> y_o=0 immediately; post-reset accept sel=1 -> y_o=0010.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decoder_pkg                                                                |
// | State encoding, one-hot decode and counter-width helpers for the decoder. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package decoder_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_HOLD  = HOLD,
    ST_PULSE = PULSE
  } state_e;

  // Widest one-hot vector the helper produces; callers slice the low NUM_OUT bits.
  localparam int ONEHOT_MAX_W = 64;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int sel, input int num_out);
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      v[i] = (i < num_out) && (i == sel);
    end
    return v;
  endfunction

  function automatic int cnt_width(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_pulse_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decoder_pulse_timer                                                        |
// | Down-counter for pulse-mode strobes: load, decrement to zero, clear.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decoder_pulse_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_clear,
  output logic             o_done,
  output logic             o_active
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over load so an enable drop never leaves a stale count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done   = (r_cnt == '0);
  assign o_active = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/decoder_onehot_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decoder_onehot_seq                                                         |
// | Registered binary-to-one-hot decoder with handshake, hold/pulse modes.    |
// | Optional macro DECODER_OOR_CHECK_EN: 1-cycle err_o on out-of-range select. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decoder_onehot_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int NUM_OUT   = 4,
  parameter int PULSE_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [NUM_OUT-1:0] y_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int                 c_cnt_w      = cnt_width(PULSE_LEN);
  localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_LEN - 1);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [NUM_OUT-1:0]        r_y;
  logic [NUM_OUT-1:0]        w_y_nxt;
  logic [ONEHOT_MAX_W-1:0]   w_dec_full;
  logic [NUM_OUT-1:0]        w_dec;
  logic                      w_in_range;
  logic                      w_accept;
  logic                      w_load;
  logic                      w_clear;
  logic                      w_oor;
  logic                      w_done;
  logic                      w_active;
  logic                      w_unused;

  assign w_dec_full = onehot(32'(sel_i), NUM_OUT);
  assign w_dec      = w_dec_full[NUM_OUT-1:0];
  assign w_in_range = |w_dec;
  assign w_unused   = &{1'b0, w_dec_full[ONEHOT_MAX_W-1:NUM_OUT], w_active};

  assign in_ready_o = (r_state != ST_PULSE) | w_done;
  assign w_accept   = in_valid_i & in_ready_o;

  decoder_pulse_timer #(
    .CNT_W (c_cnt_w)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (c_pulse_load),
    .i_clear    (w_clear),
    .o_done     (w_done),
    .o_active   (w_active)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_oor       = 1'b0;
    if (w_accept && en_i && w_in_range) begin
      // New code replaces the old one on a single edge, so there is never a zero gap.
      w_y_nxt = w_dec;
      if (mode_i) begin
        w_state_nxt = ST_PULSE;
        w_load      = 1'b1;
      end else begin
        w_state_nxt = ST_HOLD;
        w_clear     = 1'b1;
      end
    end else if (w_accept || !en_i) begin
      w_state_nxt = ST_IDLE;
      w_y_nxt     = '0;
      w_clear     = 1'b1;
      w_oor       = w_accept & en_i;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_y_nxt = '0;
        end
        ST_HOLD: begin
          w_y_nxt = r_y;
        end
        ST_PULSE: begin
          if (w_done) begin
            w_state_nxt = ST_IDLE;
            w_y_nxt     = '0;
            w_clear     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_y_nxt     = '0;
          w_clear     = 1'b1;
        end
      endcase
    end
  end

  assign y_o    = r_y;
  assign busy_o = (r_state == ST_PULSE);

`ifdef DECODER_OOR_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_oor;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_oor;

  assign w_unused_oor = w_oor;
  assign err_o        = 1'b0;
`endif

endmodule
`default_nettype wire
